mem_stage: RTL and testbench

//  - MEM pipeline stage. Consumes the EX/MEM register outputs (ctrl_mem, rd_mem, alu_result, write_data1).
//  - Performs loads/stores over a valid/ready data-memory request port with a separate response channel.
//  - Stalls upstream while an access is outstanding; drives the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_dmem_req_fsm.sv | 71 +++++++
 rtl/mem_stage.sv | 101 ++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit indices and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

  // Bit positions inside the 4-bit EX/MEM control word
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 0;

  // Timeout counter width; covers TIMEOUT_CYCLES up to 255
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  function automatic logic is_memop(input logic [3:0] ctrl);
    return ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus a one-cycle response channel.
// Latency: n/a (wiring only).
// Backpressure: request held by master until ready; response channel has none.
interface mem_stage_if #(
  parameter int XLEN = 64
) ();

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr;
  logic [XLEN-1:0] dmem_req_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_rdata;

  // The pipeline stage issues requests and consumes responses
  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  // The memory accepts requests and produces responses
  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_req_fsm.sv
// Request/response sequencer for the MEM stage: FSM, response timeout, stall generation.
// Latency: >= 2 cycles per memory op (accept, then response); non-mem ops pass in 0 extra cycles.
// Backpressure: holds request until ready; stalls upstream until response, timeout or misalign.
module dmem_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic memop,
  input  logic misalign,
  input  logic req_ready,
  input  logic rsp_valid,
  output logic req_valid,
  output logic stall_o,
  output logic rsp_done,
  output logic bus_err,
  output logic mis_hit
);

  // Last permitted cycle in WAIT_RSP: the counter reads 0 on the first waiting
  // cycle, so a value of TIMEOUT_CYCLES-1 marks the TIMEOUT_CYCLES-th cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             in_wait;

  assign in_wait = (state == WAIT_RSP);

  // Outputs are qualified with reset_n so they drop the instant reset asserts,
  // even while the upstream control word still shows a memory op.
  assign mis_hit   = reset_n & misalign & (state == IDLE);
  assign rsp_done  = reset_n & in_wait & rsp_valid;
  assign bus_err   = reset_n & in_wait & ~rsp_valid & (cnt == CNT_LAST);
  assign req_valid = reset_n & (((state == IDLE) & memop & ~mis_hit) | (state == REQ));
  assign stall_o   = reset_n & memop & ~(rsp_done | bus_err | mis_hit);

  // State and timeout counter; a response in the final cycle beats the timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && !mis_hit) begin
            cnt   <= '0;
            state <= req_ready ? WAIT_RSP : REQ;
          end
        end
        REQ: begin
          if (req_ready) begin
            cnt   <= '0;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid || cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to data memory and drives the MEM/WB register.
// Latency: non-mem op 1 edge; memory op >= 2 cycles (accept + response), bounded by TIMEOUT_CYCLES.
// Backpressure: stall_o holds EX/MEM while an access is outstanding; bubbles go to WB meanwhile.
// Optional: define MEM_ALIGN_CHECK_EN to reject accesses with alu_result[2:0] != 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3:0]            ctrl_mem,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       write_data1,
  output logic                  stall_o,
  mem_stage_if.master           dmem,
  output logic [1:0]            ctrl_wb,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic [XLEN-1:0]       mem_data_wb,
  output logic [XLEN-1:0]       alu_result_wb,
  output logic                  bus_err_o,
  output logic                  misalign_o
);

  logic memop;
  logic is_store;
  logic is_load;
  logic misaligned;
  logic req_valid;
  logic rsp_done;
  logic bus_err;
  logic mis_hit;

  // A word with both read and write set is treated as a store
  assign memop    = is_memop(ctrl_mem);
  assign is_store = ctrl_mem[CTRL_MEM_WRITE];
  assign is_load  = ctrl_mem[CTRL_MEM_READ] & ~ctrl_mem[CTRL_MEM_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memop & (alu_result[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  dmem_req_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .memop    (memop),
    .misalign (misaligned),
    .req_ready(dmem.dmem_req_ready),
    .rsp_valid(dmem.dmem_rsp_valid),
    .req_valid(req_valid),
    .stall_o  (stall_o),
    .rsp_done (rsp_done),
    .bus_err  (bus_err),
    .mis_hit  (mis_hit)
  );

  // Request fields come straight from EX/MEM, which stall_o keeps stable
  assign dmem.dmem_req_valid = req_valid;
  assign dmem.dmem_req_we    = req_valid & is_store;
  assign dmem.dmem_req_addr  = req_valid ? alu_result  : '0;
  assign dmem.dmem_req_wdata = req_valid ? write_data1 : '0;

  assign bus_err_o  = bus_err;
  assign misalign_o = mis_hit;

  // MEM/WB register: bubble while stalled or on error, load on completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_wb       <= '0;
      rd_wb         <= '0;
      mem_data_wb   <= '0;
      alu_result_wb <= '0;
    end else if (stall_o) begin
      ctrl_wb <= '0;
    end else if (memop) begin
      if (rsp_done) begin
        ctrl_wb       <= {ctrl_mem[CTRL_REG_WRITE], ctrl_mem[CTRL_MEM_TO_REG] & ~is_store};
        rd_wb         <= rd_mem;
        alu_result_wb <= alu_result;
        if (is_load) begin
          mem_data_wb <= dmem.dmem_rsp_rdata;
        end
      end else begin
        // Timeout or misaligned access: the op retires as a bubble
        ctrl_wb <= '0;
      end
    end else begin
      ctrl_wb       <= {ctrl_mem[CTRL_REG_WRITE], ctrl_mem[CTRL_MEM_TO_REG]};
      rd_wb         <= rd_mem;
      alu_result_wb <= alu_result;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load, stalled store, timeout,
// response on the final timeout cycle, reset mid-access and the alignment option.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ctrl_mem;
  logic [4:0]  rd_mem;
  logic [63:0] alu_result;
  logic [63:0] write_data1;
  logic        stall_o;
  logic [1:0]  ctrl_wb;
  logic [4:0]  rd_wb;
  logic [63:0] mem_data_wb;
  logic [63:0] alu_result_wb;
  logic        bus_err_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_if #(.XLEN(64)) dmem ();

  mem_stage #(
    .XLEN(64),
    .REG_ADDR_W(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_mem     (ctrl_mem),
    .rd_mem       (rd_mem),
    .alu_result   (alu_result),
    .write_data1  (write_data1),
    .stall_o      (stall_o),
    .dmem         (dmem),
    .ctrl_wb      (ctrl_wb),
    .rd_wb        (rd_wb),
    .mem_data_wb  (mem_data_wb),
    .alu_result_wb(alu_result_wb),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    ctrl_mem    = '0;
    rd_mem      = '0;
    alu_result  = '0;
    write_data1 = '0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rsp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_ctrl_wb", ctrl_wb, 0);
    chk("rst_rd_wb", rd_wb, 0);
    chk("rst_alu_wb", alu_result_wb, 0);
    chk("rst_mem_wb", mem_data_wb, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", dmem.dmem_req_valid, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_misalign", misalign_o, 0);
    reset_n = 1'b1;

    // ALU op passes through in one edge
    ctrl_mem = 4'b1000; rd_mem = 5'd5; alu_result = 64'h2A;
    #1;
    chk("alu_stall", stall_o, 0);
    chk("alu_valid", dmem.dmem_req_valid, 0);
    tick();
    chk("alu_ctrl_wb", ctrl_wb, 2'b10);
    chk("alu_rd_wb", rd_wb, 5);
    chk("alu_alu_wb", alu_result_wb, 64'h2A);

    // Load accepted at once, response three cycles after the request
    ctrl_mem = 4'b1110; rd_mem = 5'd7; alu_result = 64'h1000;
    dmem.dmem_req_ready = 1'b1;
    #1;
    chk("ld_valid", dmem.dmem_req_valid, 1);
    chk("ld_we", dmem.dmem_req_we, 0);
    chk("ld_addr", dmem.dmem_req_addr, 64'h1000);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall", stall_o, 1);
      tick();
      dmem.dmem_req_ready = 1'b0;
      chk("ld_bubble", ctrl_wb, 0);
      chk("ld_rd_hold", rd_wb, 5);
      #1;
    end
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 64'hDEAD_BEEF;
    #1;
    chk("ld_rsp_stall", stall_o, 0);
    tick();
    dmem.dmem_rsp_valid = 1'b0; ctrl_mem = 4'b0000;
    chk("ld_ctrl_wb", ctrl_wb, 2'b11);
    chk("ld_rd_wb", rd_wb, 7);
    chk("ld_mem_wb", mem_data_wb, 64'hDEAD_BEEF);
    chk("ld_alu_wb", alu_result_wb, 64'h1000);

    // Store with ready low for two cycles
    ctrl_mem = 4'b0001; rd_mem = 5'd9; alu_result = 64'h2000;
    write_data1 = 64'h1234_5678_9ABC_DEF0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("st_valid", dmem.dmem_req_valid, 1);
      chk("st_we", dmem.dmem_req_we, 1);
      chk("st_addr", dmem.dmem_req_addr, 64'h2000);
      chk("st_wdata", dmem.dmem_req_wdata, 64'h1234_5678_9ABC_DEF0);
      chk("st_stall", stall_o, 1);
      tick();
      chk("st_bubble", ctrl_wb, 0);
      #1;
    end
    dmem.dmem_req_ready = 1'b1;
    #1;
    chk("st_valid_acc", dmem.dmem_req_valid, 1);
    tick();
    dmem.dmem_req_ready = 1'b0;
    #1;
    chk("st_wait_valid", dmem.dmem_req_valid, 0);
    chk("st_wait_stall", stall_o, 1);
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 64'h5555;
    #1;
    chk("st_ack_stall", stall_o, 0);
    tick();
    dmem.dmem_rsp_valid = 1'b0; ctrl_mem = 4'b0000;
    chk("st_ctrl_wb", ctrl_wb, 2'b00);
    chk("st_rd_wb", rd_wb, 9);
    chk("st_mem_hold", mem_data_wb, 64'hDEAD_BEEF);
    chk("st_alu_wb", alu_result_wb, 64'h2000);

    // No response: bus error on the fourth cycle after the request
    ctrl_mem = 4'b1110; rd_mem = 5'd3; alu_result = 64'h3000;
    dmem.dmem_req_ready = 1'b1;
    #1;
    chk("to_valid", dmem.dmem_req_valid, 1);
    tick();
    dmem.dmem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_no_err", bus_err_o, 0);
      chk("to_stall", stall_o, 1);
      tick();
    end
    #1;
    chk("to_bus_err", bus_err_o, 1);
    chk("to_err_stall", stall_o, 0);
    tick();
    ctrl_mem = 4'b0000;
    chk("to_bubble", ctrl_wb, 0);
    chk("to_rd_hold", rd_wb, 9);
    #1;
    chk("to_err_pulse", bus_err_o, 0);
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 64'hBAD;
    tick();
    dmem.dmem_rsp_valid = 1'b0;
    chk("to_late_rsp", mem_data_wb, 64'hDEAD_BEEF);
    #1;
    chk("to_idle_stall", stall_o, 0);
    chk("to_idle_valid", dmem.dmem_req_valid, 0);

    // Response arriving in the final timeout cycle wins
    ctrl_mem = 4'b1110; rd_mem = 5'd4; alu_result = 64'h4000;
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    repeat (3) tick();
    dmem.dmem_rsp_valid = 1'b1; dmem.dmem_rsp_rdata = 64'hCAFE;
    #1;
    chk("edge_no_err", bus_err_o, 0);
    chk("edge_stall", stall_o, 0);
    tick();
    dmem.dmem_rsp_valid = 1'b0; ctrl_mem = 4'b0000;
    chk("edge_ctrl_wb", ctrl_wb, 2'b11);
    chk("edge_rd_wb", rd_wb, 4);
    chk("edge_mem_wb", mem_data_wb, 64'hCAFE);

    // Reset asserted while waiting for a response
    ctrl_mem = 4'b1110; rd_mem = 5'd6; alu_result = 64'h5000;
    dmem.dmem_req_ready = 1'b1;
    tick();
    dmem.dmem_req_ready = 1'b0;
    #1;
    chk("rw_stall_pre", stall_o, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_valid", dmem.dmem_req_valid, 0);
    chk("rw_stall", stall_o, 0);
    chk("rw_ctrl_wb", ctrl_wb, 0);
    chk("rw_rd_wb", rd_wb, 0);
    chk("rw_mem_wb", mem_data_wb, 0);
    chk("rw_alu_wb", alu_result_wb, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rw_idle_req", dmem.dmem_req_valid, 1);
    chk("rw_idle_stall", stall_o, 1);
    ctrl_mem = 4'b0000;
    #1;
    chk("rw_idle_clear", dmem.dmem_req_valid, 0);
    tick();

    // Misaligned address 0x1004
    ctrl_mem = 4'b1000; rd_mem = 5'd2; alu_result = 64'h77;
    tick();
    ctrl_mem = 4'b1110; rd_mem = 5'd8; alu_result = 64'h1004;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("ma_misalign", misalign_o, 1);
    chk("ma_valid", dmem.dmem_req_valid, 0);
    chk("ma_stall", stall_o, 0);
    tick();
    ctrl_mem = 4'b0000;
    chk("ma_bubble", ctrl_wb, 0);
    chk("ma_rd_hold", rd_wb, 2);
    #1;
    chk("ma_pulse", misalign_o, 0);
`else
    chk("ma_misalign", misalign_o, 0);
    chk("ma_valid", dmem.dmem_req_valid, 1);
    chk("ma_addr", dmem.dmem_req_addr, 64'h1004);
    chk("ma_stall", stall_o, 1);
    ctrl_mem = 4'b0000;
    #1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
